// File: rtl/decode_token.sv
// LZS token parser: decodes literals, match offsets/lengths and the end marker from a 13-bit
// MSB-first window, tells the aligner how many bits to drop and emits literal/copy commands.
module decode_token (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [12:0] stream_data,
  input  logic        stream_valid,
  output logic        stream_ack,
  output logic [3:0]  stream_width,
  input  logic        out_full,
  output logic        out_valid,
  output logic        out_lit,
  output logic [7:0]  out_data,
  output logic [10:0] out_offset,
  output logic [4:0]  out_len,
  output logic        out_end,
  output logic        out_err
);

  typedef enum logic [1:0] {StToken, StLen, StExt, StDone} state_e;

  state_e      state_q, state_d;
  logic [10:0] offset_q, offset_d;
  logic        ack_d, valid_d, lit_d, end_d, err_d;
  logic [3:0]  width_d;
  logic [7:0]  data_d;
  logic [4:0]  len_d;

  logic [6:0]  short_off;
  logic [10:0] long_off;
  logic [3:0]  len_code;
  logic [3:0]  len_nib;
  logic [3:0]  ext_nib;
  logic        eval;

  assign short_off = stream_data[10:4];
  assign long_off  = stream_data[10:0];
  assign len_code  = stream_data[12:9];
  assign len_nib   = stream_data[8:5];
  assign ext_nib   = stream_data[12:9];

  // A registered ack still on the wire means the window has not shifted yet.
  assign eval = ce && stream_valid && !stream_ack;

  assign out_offset = offset_q;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    ack_d    = 1'b0;
    width_d  = 4'd0;
    valid_d  = 1'b0;
    lit_d    = out_lit;
    data_d   = out_data;
    len_d    = out_len;
    end_d    = 1'b0;
    err_d    = out_err;

    if (eval) begin
      unique case (state_q)
        StToken: begin
          if (!stream_data[12]) begin
            if (!out_full) begin
              ack_d   = 1'b1;
              width_d = 4'd9;
              valid_d = 1'b1;
              lit_d   = 1'b1;
              data_d  = stream_data[11:4];
            end
          end else if (stream_data[11]) begin
            ack_d   = 1'b1;
            width_d = 4'd9;
            if (short_off != 7'd0) begin
              offset_d = {4'd0, short_off};
              state_d  = StLen;
            end else begin
              end_d   = 1'b1;
              state_d = StDone;
            end
          end else begin
            ack_d   = 1'b1;
            width_d = 4'd13;
            if (long_off != 11'd0) begin
              offset_d = long_off;
              state_d  = StLen;
            end else begin
              err_d   = 1'b1;
              state_d = StDone;
            end
          end
        end

        StLen: begin
          if (!out_full) begin
            ack_d   = 1'b1;
            valid_d = 1'b1;
            lit_d   = 1'b0;
            state_d = StToken;
            if (len_code[3:2] != 2'b11) begin
              width_d = 4'd2;
              len_d   = 5'd2 + {3'd0, len_code[3:2]};
            end else if (len_code[1:0] != 2'b11) begin
              width_d = 4'd4;
              len_d   = 5'd5 + {3'd0, len_code[1:0]};
            end else begin
              width_d = 4'd8;
              if (len_nib != 4'hf) begin
                len_d = 5'd8 + {1'b0, len_nib};
              end else begin
                len_d   = 5'd23;
                state_d = StExt;
              end
            end
          end
        end

        StExt: begin
          if (ext_nib == 4'd0) begin
            // Terminating zero nibble carries no bytes, so downstream space is irrelevant.
            ack_d   = 1'b1;
            width_d = 4'd4;
            state_d = StToken;
          end else if (!out_full) begin
            ack_d   = 1'b1;
            width_d = 4'd4;
            valid_d = 1'b1;
            lit_d   = 1'b0;
            len_d   = {1'b0, ext_nib};
            state_d = (ext_nib == 4'hf) ? StExt : StToken;
          end
        end

        StDone: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StToken;
      offset_q     <= 11'd0;
      stream_ack   <= 1'b0;
      stream_width <= 4'd0;
      out_valid    <= 1'b0;
      out_lit      <= 1'b0;
      out_data     <= 8'd0;
      out_len      <= 5'd0;
      out_end      <= 1'b0;
      out_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      stream_ack   <= ack_d;
      stream_width <= width_d;
      out_valid    <= valid_d;
      out_lit      <= lit_d;
      out_data     <= data_d;
      out_len      <= len_d;
      out_end      <= end_d;
      out_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_decode_token.sv
// Bench for decode_token: a bit-queue aligner model feeds token streams built from
// literal/match descriptions; expected commands and ack widths come from LZS arithmetic.
module tb_decode_token;

  logic        clk = 1'b0;
  logic        rst, ce;
  logic [12:0] stream_data;
  logic        stream_valid;
  logic        stream_ack;
  logic [3:0]  stream_width;
  logic        out_full;
  logic        out_valid, out_lit;
  logic [7:0]  out_data;
  logic [10:0] out_offset;
  logic [4:0]  out_len;
  logic        out_end, out_err;

  always #5 clk = ~clk;

  decode_token dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .stream_ack   (stream_ack),
    .stream_width (stream_width),
    .out_full     (out_full),
    .out_valid    (out_valid),
    .out_lit      (out_lit),
    .out_data     (out_data),
    .out_offset   (out_offset),
    .out_len      (out_len),
    .out_end      (out_end),
    .out_err      (out_err)
  );

  localparam int MaxBits = 8192;

  typedef struct {
    int kind;  // 0 literal, 1 copy, 2 end marker
    int data;
    int off;
    int len;
  } cmd_t;

  logic bits [MaxBits];
  int   nbits = 0;
  int   ptr = 0;
  logic load = 1'b0;
  logic gap = 1'b0;

  cmd_t exp_q[$];
  int   ack_q[$];
  int   exp_ptr = 0;

  int checks = 0;
  int passed = 0;
  int ack_cnt = 0;
  int valid_cnt = 0;
  int ce_off_pct = 0;
  int full_pct = 0;
  int gap_pct = 0;

  logic prev_ce = 1'b0;
  logic prev_full = 1'b0;

  // Aligner: drops the acked bits on the ack cycle; zero-pads past the end of data.
  always @(posedge clk) begin
    if (load) ptr <= 0;
    else if (stream_ack) ptr <= ptr + int'(stream_width);
  end

  always_comb begin
    stream_data = '0;
    for (int i = 0; i < 13; i++) begin
      if (ptr + i < nbits) stream_data[12-i] = bits[ptr+i];
    end
    stream_valid = (ptr < nbits) && !gap;
  end

  always @(posedge clk) begin
    prev_ce   <= ce;
    prev_full <= out_full;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    cmd_t e;
    if (!rst) begin
      if (stream_ack) begin
        ack_cnt++;
        check("ack_ce", prev_ce, 1);
        if (ack_q.size() == 0) check("ack_unexpected", ack_q.size(), 1);
        else check("ack_width", int'(stream_width), ack_q.pop_front());
      end else begin
        check("width_idle", int'(stream_width), 0);
      end
      if (out_valid) begin
        valid_cnt++;
        check("cmd_ce", prev_ce, 1);
        check("cmd_full_at_decision", prev_full, 0);
        check("cmd_not_end", out_end, 0);
        if (exp_q.size() == 0) begin
          check("cmd_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("cmd_kind", out_lit ? 0 : 1, e.kind);
          if (e.kind == 0) begin
            check("lit_data", int'(out_data), e.data);
          end else begin
            check("copy_offset", int'(out_offset), e.off);
            check("copy_len", int'(out_len), e.len);
          end
        end
      end
      if (out_end) begin
        check("end_ce", prev_ce, 1);
        if (exp_q.size() == 0) begin
          check("end_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("end_kind", 2, e.kind);
        end
      end
    end
  end

  task automatic push_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bits[nbits] = v[i];
      nbits++;
    end
  endtask

  task automatic exp_ack(input int w);
    ack_q.push_back(w);
    exp_ptr += w;
  endtask

  task automatic exp_cmd(input int kind, input int data, input int off, input int len);
    cmd_t c;
    c.kind = kind;
    c.data = data;
    c.off  = off;
    c.len  = len;
    exp_q.push_back(c);
  endtask

  task automatic model_literal(input int b);
    push_bits(16'(b) & 16'h00ff, 9);
    exp_ack(9);
    exp_cmd(0, b, 0, 0);
  endtask

  // Encode a match in LZS form; chunks are 23 then 15s then the remainder.
  task automatic model_match(input int off, input int len, input bit short_form);
    logic [10:0] o;
    int rem;
    o = off[10:0];
    if (short_form) begin
      push_bits({7'd0, 2'b11, o[6:0]}, 9);
      exp_ack(9);
    end else begin
      push_bits({3'd0, 2'b10, o}, 13);
      exp_ack(13);
    end
    if (len <= 4) begin
      push_bits(16'(len - 2), 2);
      exp_ack(2);
      exp_cmd(1, 0, off, len);
    end else if (len <= 7) begin
      push_bits(16'(12 + len - 5), 4);
      exp_ack(4);
      exp_cmd(1, 0, off, len);
    end else if (len <= 22) begin
      push_bits(16'(240 + len - 8), 8);
      exp_ack(8);
      exp_cmd(1, 0, off, len);
    end else begin
      push_bits(16'h00ff, 8);
      exp_ack(8);
      exp_cmd(1, 0, off, 23);
      rem = len - 23;
      while (rem >= 15) begin
        push_bits(16'h000f, 4);
        exp_ack(4);
        exp_cmd(1, 0, off, 15);
        rem -= 15;
      end
      push_bits(16'(rem), 4);
      exp_ack(4);
      if (rem > 0) exp_cmd(1, 0, off, rem);
    end
  endtask

  task automatic random_stream(input int ntok, input bit with_end);
    for (int k = 0; k < ntok; k++) begin
      int off;
      int len;
      bit sf;
      if ($urandom_range(0, 1) == 0) begin
        model_literal(int'($urandom_range(0, 255)));
      end else begin
        off = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 127))
                                          : int'($urandom_range(1, 2047));
        sf  = (off < 128) && ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 2))
          0:       len = int'($urandom_range(2, 7));
          1:       len = int'($urandom_range(8, 22));
          default: len = int'($urandom_range(23, 70));
        endcase
        model_match(off, len, sf);
      end
    end
    if (with_end) begin
      push_bits(16'h0180, 9);
      exp_ack(9);
      exp_cmd(2, 0, 0, 0);
      push_bits(16'h0181, 9);  // must never be consumed
    end
  endtask

  task automatic new_test();
    exp_q.delete();
    ack_q.delete();
    nbits   = 0;
    exp_ptr = 0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    load     = 1'b1;
    ce       = 1'b1;
    out_full = 1'b0;
    gap      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", int'({stream_ack, stream_width, out_valid, out_lit, out_end, out_err}), 0);
    check("rst_data", int'({out_data, out_len}), 0);
    check("rst_offset", int'(out_offset), 0);
    rst  = 1'b0;
    load = 1'b0;
  endtask

  task automatic drive_random();
    ce       = ($urandom_range(0, 99) >= ce_off_pct);
    out_full = ($urandom_range(0, 99) < full_pct);
    gap      = ($urandom_range(0, 99) < gap_pct);
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() + ack_q.size()) > 0 && n < budget) begin
      drive_random();
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size() + ack_q.size(), 0);
    ce       = 1'b1;
    out_full = (full_pct >= 100);
    gap      = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("final_ptr", ptr, exp_ptr);
  endtask

  task automatic set_mode(input int c, input int f, input int g);
    ce_off_pct = c;
    full_pct   = f;
    gap_pct    = g;
  endtask

  initial begin
    int a0;
    int v0;
    rst = 1'b1;
    ce = 1'b0;
    out_full = 1'b0;

    // Literal 0x41: strobe exactly one cycle after the decision edge.
    new_test();
    push_bits(16'h0041, 9);
    exp_ack(9);
    exp_cmd(0, 8'h41, 0, 0);
    set_mode(0, 0, 0);
    do_reset();
    @(posedge clk);
    #1;
    check("lit_strobe", int'({stream_ack, out_valid, out_lit}), 7);
    check("lit_data_now", int'(out_data), 8'h41);
    check("lit_width_now", int'(stream_width), 9);
    @(posedge clk);
    #1;
    check("lit_pulse_drop", int'({stream_ack, out_valid}), 0);
    run_drain(200);

    // Hand-coded matches: offset 5 len 3; offset 1500 len 30; len 22; len 23 exactly.
    new_test();
    push_bits(16'h0185, 9);  push_bits(16'h0001, 2);
    exp_ack(9); exp_ack(2); exp_cmd(1, 0, 5, 3);
    push_bits(16'h15dc, 13); push_bits(16'h00ff, 8); push_bits(16'h0007, 4);
    exp_ack(13); exp_ack(8); exp_ack(4);
    exp_cmd(1, 0, 1500, 23); exp_cmd(1, 0, 1500, 7);
    push_bits(16'h0185, 9);  push_bits(16'h00fe, 8);
    exp_ack(9); exp_ack(8); exp_cmd(1, 0, 5, 22);
    push_bits(16'h0185, 9);  push_bits(16'h00ff, 8); push_bits(16'h0000, 4);
    exp_ack(9); exp_ack(8); exp_ack(4); exp_cmd(1, 0, 5, 23);
    set_mode(20, 30, 10);
    do_reset();
    run_drain(2000);
    check("no_err_matches", out_err, 0);

    // End marker with downstream full: consumed anyway, then nothing further.
    new_test();
    push_bits(16'h0180, 9);
    push_bits(16'h0181, 9);
    exp_ack(9);
    exp_cmd(2, 0, 0, 0);
    set_mode(0, 100, 0);
    do_reset();
    run_drain(200);

    // Long offset 0 sets the sticky error and stops parsing.
    new_test();
    push_bits(16'h1000, 13);
    push_bits(16'h0181, 9);
    exp_ack(13);
    set_mode(10, 30, 10);
    do_reset();
    run_drain(200);
    check("err_sticky", out_err, 1);

    // Downstream full for 10 cycles over a literal.
    new_test();
    model_literal(8'h5a);
    set_mode(0, 0, 0);
    do_reset();
    a0 = ack_cnt;
    v0 = valid_cnt;
    out_full = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("stall_no_ack", ack_cnt - a0, 0);
    check("stall_no_valid", valid_cnt - v0, 0);
    out_full = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("stall_one_ack", ack_cnt - a0, 1);
    check("stall_one_valid", valid_cnt - v0, 1);
    run_drain(100);

    // Randomized streams.
    for (int r = 0; r < 4; r++) begin
      new_test();
      random_stream(60, r == 3);
      set_mode(15, 25, 10);
      do_reset();
      run_drain(20000);
      check("no_err_random", out_err, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/decode_token.md
# decode_token

LZS token parser for the decompression path. Sits directly downstream of the bit-stream aligner: it reads a 13-bit MSB-first window of compressed bits, decodes literals, match offsets, lengths and the end marker, and tells the aligner how many bits to drop. It emits one literal or copy command per transaction to the history/copy engine. Long matches are split into same-offset copy chunks of at most 23 bytes.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable; low freezes all state, and pulse outputs drop to 0
- stream_data  in  13  bit window; [12] is the next unconsumed bit
- stream_valid  in  1  all 13 window bits are valid (aligner zero-pads at end of data)
- stream_ack  out  1  one-cycle pulse: consume stream_width bits
- stream_width  out  4  bits consumed (2, 4, 8, 9 or 13); held 0 when not acking
- out_full  in  1  downstream cannot accept a command this cycle
- out_valid  out  1  one-cycle command strobe
- out_lit  out  1  1 = literal, 0 = copy
- out_data  out  8  literal byte; valid when out_lit=1
- out_offset  out  11  copy distance, 1..2047
- out_len  out  5  copy length, 1..23
- out_end  out  1  one-cycle pulse when the end marker is consumed
- out_err  out  1  sticky: long-form offset 0 was decoded

## Operation
- States: TOKEN, LEN, EXT, DONE. Reset: state TOKEN; all outputs 0; offset register 0.
- The block evaluates only when ce=1, stream_valid=1, stream_ack=0 (registered ack still on the wire) and the state is not DONE. Any step that emits a command also requires out_full=0.
- TOKEN, [12]=0: literal. out_data=[11:4], out_lit=1, width 9; stays in TOKEN.
- TOKEN, [12:11]=11: short offset [10:4], width 9. If the offset is non-zero, latch it and go to LEN. If it is zero, this is the end marker: pulse out_end and go to DONE; out_full is ignored.
- TOKEN, [12:11]=10: long offset [10:0], width 13. If non-zero, latch it and go to LEN. If zero, set out_err, ack 13 bits and go to DONE.
- LEN (always emits a copy with the latched offset):
  - 00 → len 2, 01 → len 3, 10 → len 4; width 2 each.
  - 1100 → len 5, 1101 → len 6, 1110 → len 7; width 4 each.
  - 1111 followed by n=[8:5], width 8: if n<15, len 8+n and go to TOKEN; if n=15, len 23 and go to EXT.
- EXT, n=[12:9], width 4:
  - n=15: emit len 15 and stay in EXT.
  - 1≤n≤14: emit len n and go to TOKEN.
  - n=0: no emit (out_full ignored) and go to TOKEN.
- DONE: no acks and no commands until rst.
- Total copy length = sum of chunks. This is equal to the LZS length 8 + Σnibbles.

## Timing
- All outputs are registered. A decision in cycle t drives stream_ack/stream_width and out_* in cycle t+1, each high for one cycle.
- The aligner shifts on the ack cycle, so fresh data appears in t+2. Peak throughput is one step every 2 cycles.
- out_full is sampled in the decision cycle. A full downstream stalls without acking, so no command is ever dropped.
- ce=0 mid-stream: no decision is made and state is held. A pending pulse is not re-issued.
- rst mid-match discards the latched offset and returns to TOKEN. rst clears out_err.
- stream_valid=0: wait indefinitely with no side effects.

## Test plan
- Literal 0x41 (window 0_01000001_0000) → one cycle later: out_lit=1, out_data=0x41, stream_width=9, ack pulse. State stays TOKEN.
- Short match offset 5, length 3 (11_0000101 then 01) → ack 9, then ack 2. Copy offset=5, len=3.
- Long match offset 1500, length 30 (10_10111011100, then 1111_1111, then 0111) → chunks len 23 then 7 at offset 1500. Acks 13, 8, 4.
- Length 22 (1111_1110), then length 23 exactly (1111_1111_0000) → single chunks 22 and 23. The EXT 0000 nibble emits nothing but acks 4.
- End marker 110000000 with out_full=1 → out_end pulse and ack 9. No further acks despite stream_valid=1. rst returns to TOKEN.
- Long offset 0 → out_err=1 and state DONE. Separately: out_full held 10 cycles during a literal → no ack or out_valid until it is released, then exactly one of each.
